memory_control: RTL

MEMORY_CONTROL -- requirements
Module: memory_control

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/memory_control_if.sv | 47 ++++
 rtl/llsc_link.sv | 44 ++++
 rtl/memory_control.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_types_pkg
// Brief   : Shared CPU/memory types: RAM handshake state and bus word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

   localparam int c_WORD_W = 32;

   typedef logic [c_WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

`default_nettype wire

// File: rtl/memory_control_if.sv
//------------------------------------------------------------------------------
// Module  : memory_control_if
// Brief   : CPU fetch/data request bus plus RAM-side request bus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface memory_control_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      ihit;
   word_t     iload;

   logic      dREN;
   logic      dWEN;
   logic      datomic;
   word_t     daddr;
   word_t     dstore;
   logic      dhit;
   word_t     dload;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   logic      merr;

   // Controller side.
   modport slave (
      input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, merr
   );

   // CPU and RAM side.
   modport master (
      output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, merr
   );

endinterface

`default_nettype wire

// File: rtl/llsc_link.sv
//------------------------------------------------------------------------------
// Module  : llsc_link
// Brief   : Load-linked reservation register with set, clear and address match.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module llsc_link
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  i_set,
   input  word_t i_set_addr,
   input  logic  i_clr,
   input  word_t i_chk_addr,
   output logic  o_valid,
   output word_t o_addr,
   output logic  o_match
);

   logic  r_valid;
   word_t r_addr;

   // Set and clear never coincide: set comes from an LL hit, clear from SC or a write.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
      end else if (i_set) begin
         r_valid <= 1'b1;
         r_addr  <= i_set_addr;
      end else if (i_clr) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_addr  = r_addr;
   assign o_match = r_valid && (r_addr == i_chk_addr);

endmodule

`default_nettype wire

// File: rtl/memory_control.sv
//------------------------------------------------------------------------------
// Module  : memory_control
// Brief   : Arbitrates instruction fetch and data (incl. LL/SC) onto one RAM port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memory_control
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic            CLK,
   input  logic            nRST,
   memory_control_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DACC   = 3'd1,
      IACC   = 3'd2,
      SCFAIL = 3'd3,
      ERR    = 3'd4
   } state_t;

   localparam logic [31:0] c_WAIT_LAST = 32'(TIMEOUT - 1);

   state_t      r_state;
   word_t       r_addr;
   word_t       r_store;
   logic        r_write;
   logic        r_atomic;
   logic        r_ram_ren;
   logic        r_ram_wen;
   logic        r_merr;
   logic [31:0] r_wait;

   logic        w_d_req;
   logic        w_sc_req;
   logic        w_access;
   logic        w_ram_err;
   logic        w_dacc_hit;
   logic        w_iacc_hit;
   logic        w_link_set;
   logic        w_link_clr;
   logic        w_wr_kill;
   logic        w_link_valid;
   word_t       w_link_addr;
   logic        w_link_match;

   assign w_d_req    = bus.dREN | bus.dWEN;
   assign w_sc_req   = bus.datomic & bus.dWEN;
   assign w_access   = (bus.ramstate == ACCESS);
   assign w_ram_err  = (bus.ramstate == ERROR);
   assign w_dacc_hit = (r_state == DACC) && w_access;
   assign w_iacc_hit = (r_state == IACC) && w_access;

   // Reservation bookkeeping: LL hit sets it; any SC completion or a plain
   // write landing on the reserved word drops it.
   assign w_link_set = w_dacc_hit & r_atomic & ~r_write;
   assign w_wr_kill  = w_dacc_hit & ~r_atomic & r_write & w_link_valid
                       & (r_addr == w_link_addr);
   assign w_link_clr = (w_dacc_hit & r_atomic & r_write)
                       | (r_state == SCFAIL)
                       | w_wr_kill;

   llsc_link u_llsc_link (
      .CLK        (CLK),
      .nRST       (nRST),
      .i_set      (w_link_set),
      .i_set_addr (r_addr),
      .i_clr      (w_link_clr),
      .i_chk_addr (bus.daddr),
      .o_valid    (w_link_valid),
      .o_addr     (w_link_addr),
      .o_match    (w_link_match)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_store   <= '0;
         r_write   <= 1'b0;
         r_atomic  <= 1'b0;
         r_ram_ren <= 1'b0;
         r_ram_wen <= 1'b0;
         r_merr    <= 1'b0;
         r_wait    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_wait <= '0;
               if (w_d_req) begin
                  r_addr   <= bus.daddr;
                  r_store  <= bus.dstore;
                  r_write  <= bus.dWEN;
                  r_atomic <= bus.datomic;
                  // A failing SC is resolved here, before any RAM traffic.
                  if (w_sc_req && !w_link_match) begin
                     r_state <= SCFAIL;
                  end else begin
                     r_state   <= DACC;
                     r_ram_ren <= ~bus.dWEN;
                     r_ram_wen <= bus.dWEN;
                  end
               end else if (bus.iREN) begin
                  r_addr    <= bus.iaddr;
                  r_store   <= '0;
                  r_write   <= 1'b0;
                  r_atomic  <= 1'b0;
                  r_state   <= IACC;
                  r_ram_ren <= 1'b1;
                  r_ram_wen <= 1'b0;
               end
            end
            DACC, IACC: begin
               if (w_access) begin
                  r_state   <= IDLE;
                  r_ram_ren <= 1'b0;
                  r_ram_wen <= 1'b0;
               end else if (w_ram_err || (r_wait >= c_WAIT_LAST)) begin
                  r_state   <= ERR;
                  r_merr    <= 1'b1;
                  r_ram_ren <= 1'b0;
                  r_ram_wen <= 1'b0;
               end else begin
                  r_wait <= r_wait + 32'd1;
               end
            end
            SCFAIL: begin
               r_state <= IDLE;
            end
            ERR: begin
               r_merr <= 1'b1;
            end
            default: begin
               r_state   <= IDLE;
               r_ram_ren <= 1'b0;
               r_ram_wen <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ihit     = w_iacc_hit;
   assign bus.iload    = w_iacc_hit ? bus.ramload : '0;
   assign bus.dhit     = w_dacc_hit | (r_state == SCFAIL);
   assign bus.dload    = w_dacc_hit ? ((r_atomic && r_write) ? 32'd1 : bus.ramload) : '0;
   assign bus.ramREN   = r_ram_ren;
   assign bus.ramWEN   = r_ram_wen;
   assign bus.ramaddr  = (r_ram_ren | r_ram_wen) ? r_addr : '0;
   assign bus.ramstore = r_ram_wen ? r_store : '0;
   assign bus.merr     = r_merr;

endmodule

`default_nettype wire
